// File: rtl/flash_op_arbiter.sv
// Arbitrates info/log/data writes and page reads onto the flash controllers: one grant, one start pulse, one ack.
// Start pulse 2 edges after req in IDLE; a stalled completion ends in ERR after TIMEOUT_CYCLES. Optional ARB_ROUND_ROBIN_EN.
module flash_op_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_info,
    input  logic       req_log,
    input  logic       req_data,
    input  logic       req_read,
    input  logic       end_write,
    input  logic       end_read,
    input  logic       err_clr,
    output logic       en_write,
    output logic       en_write_info,
    output logic       en_log_write,
    output logic       en_read,
    output logic       ack_info,
    output logic       ack_log,
    output logic       ack_data,
    output logic       ack_read,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state, state_nxt;
    logic [23:0] cnt, cnt_nxt;
    logic [1:0]  grant_q, grant_nxt;
    logic [1:0]  winner;
    logic        end_write_q, end_read_q;
    logic        wr_edge, rd_edge, done_edge;
    logic [3:0]  req_vec;
    logic        any_req;
    logic        live;

    assign req_vec   = {req_read, req_data, req_log, req_info};
    assign any_req   = |req_vec;
    assign wr_edge   = end_write & ~end_write_q;
    assign rd_edge   = end_read & ~end_read_q;
    assign done_edge = (grant_q == 2'd3) ? rd_edge : wr_edge;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] cand;
    logic       found;

    // Search starts just after the last completed grant.
    always_comb begin
        winner = 2'd0;
        cand   = 2'd0;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr + 2'(i + 1);
            if (!found && req_vec[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 2'd3;
        end else if (state == S_DONE) begin
            rr_ptr <= grant_q;
        end
    end
`else
    always_comb begin
        winner = 2'd3;
        if (req_info) begin
            winner = 2'd0;
        end else if (req_log) begin
            winner = 2'd1;
        end else if (req_data) begin
            winner = 2'd2;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 24'd0;
            grant_q     <= 2'd0;
            end_write_q <= 1'b0;
            end_read_q  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            grant_q     <= grant_nxt;
            end_write_q <= end_write;
            end_read_q  <= end_read;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        grant_nxt = grant_q;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nxt = S_ARB;
                end
            end
            S_ARB: begin
                if (any_req) begin
                    grant_nxt = winner;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = 24'd0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion wins over a timeout landing on the same cycle.
                if (done_edge) begin
                    state_nxt = S_DONE;
                end else if (cnt == TIMEOUT_CYCLES - 24'd1) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while rst is asserted, even before the reset edge lands.
    assign live = ~rst;

    always_comb begin
        en_write      = 1'b0;
        en_read       = 1'b0;
        en_write_info = 1'b0;
        en_log_write  = 1'b0;
        ack_info      = 1'b0;
        ack_log       = 1'b0;
        ack_data      = 1'b0;
        ack_read      = 1'b0;
        grant_id      = 2'd0;
        busy          = 1'b0;
        timeout_err   = 1'b0;
        if (live) begin
            grant_id    = grant_q;
            busy        = (state != S_IDLE);
            timeout_err = (state == S_ERR);
            if (state == S_ISSUE) begin
                en_write = (grant_q != 2'd3);
                en_read  = (grant_q == 2'd3);
            end
            if (state == S_ISSUE || state == S_WAIT || state == S_DONE) begin
                en_write_info = (grant_q == 2'd0);
                en_log_write  = (grant_q == 2'd1);
            end
            if (state == S_DONE) begin
                ack_info = (grant_q == 2'd0);
                ack_log  = (grant_q == 2'd1);
                ack_data = (grant_q == 2'd2);
                ack_read = (grant_q == 2'd3);
            end
        end
    end

endmodule
